fwd_hazard_unit: RTL and testbench

- Parametrised next-generation forwarding and hazard block for the pipelined datapath, placed between the ID/EX latch and the ALU operand muxes.
- Serves NREAD execute-stage read ports from NSTAGE downstream write stages, plus a one-entry retired-write buffer.
- Owns load-use bubble insertion and stall generation when forwarded data is not yet ready.
- Keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/fwd_hazard_unit.sv | 80 ++++++++
 tb/tb_fwd_hazard_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX-stage operand forwarding, retired-write buffer, load-use bubble and not-ready stall control
module fwd_hazard_unit #(
  parameter int NREAD  = 2,
  parameter int NSTAGE = 2,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NREAD*REG_W-1:0]   ex_rsel,
  input  logic [NREAD*DATA_W-1:0]  ex_rdat,
  input  logic [NREAD*REG_W-1:0]   id_rsel,
  input  logic                     ex_wen,
  input  logic [REG_W-1:0]         ex_wsel,
  input  logic                     ex_is_load,
  input  logic [NSTAGE-1:0]        stage_wen,
  input  logic [NSTAGE*REG_W-1:0]  stage_wsel,
  input  logic [NSTAGE*DATA_W-1:0] stage_dat,
  input  logic [NSTAGE-1:0]        stage_rdy,
  input  logic                     pipe_en,
  input  logic                     clr_cnt,
  output logic [NREAD*DATA_W-1:0]  rdat_out,
  output logic [NREAD-1:0]         fwd_hit,
  output logic                     stall_req,
  output logic                     bubble,
  output logic [CNT_W-1:0]         stall_cnt
);
  typedef enum logic {RUN, LU_BUBBLE} state_t;
  state_t state, state_nxt;
  logic rb_valid;
  logic [REG_W-1:0] rb_sel;
  logic [DATA_W-1:0] rb_dat;
  logic [NREAD-1:0] nr_stall;
  logic lu_match, lu;
  // Scan oldest to youngest so the youngest matching source overwrites the rest
  always_comb begin
    rdat_out = ex_rdat;
    fwd_hit  = '0;
    nr_stall = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (nRST && rb_valid && rb_sel == ex_rsel[i*REG_W +: REG_W]) begin
        rdat_out[i*DATA_W +: DATA_W] = rb_dat;
        fwd_hit[i] = 1'b1;
      end
      for (int s = NSTAGE-1; s >= 0; s--) begin
        if (nRST && stage_wen[s] && stage_wsel[s*REG_W +: REG_W] != '0 &&
            stage_wsel[s*REG_W +: REG_W] == ex_rsel[i*REG_W +: REG_W]) begin
          rdat_out[i*DATA_W +: DATA_W] = stage_dat[s*DATA_W +: DATA_W];
          fwd_hit[i]  = 1'b1;
          nr_stall[i] = ~stage_rdy[s];
        end
      end
    end
  end
  always_comb begin
    lu_match = 1'b0;
    for (int i = 0; i < NREAD; i++)
      lu_match = lu_match | (id_rsel[i*REG_W +: REG_W] == ex_wsel);
  end
  assign lu        = nRST && state == RUN && pipe_en && ex_is_load && ex_wen && ex_wsel != '0 && lu_match;
  assign state_nxt = lu ? LU_BUBBLE : RUN;
  assign stall_req = lu | (nRST & (|nr_stall));
  assign bubble    = lu;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RUN;
      rb_valid  <= 1'b0;
      rb_sel    <= '0;
      rb_dat    <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rb_valid  <= stage_wen[NSTAGE-1] && stage_wsel[(NSTAGE-1)*REG_W +: REG_W] != '0;
      rb_sel    <= stage_wsel[(NSTAGE-1)*REG_W +: REG_W];
      rb_dat    <= stage_dat[(NSTAGE-1)*DATA_W +: DATA_W];
      stall_cnt <= clr_cnt ? '0 : (stall_req && stall_cnt != '1) ? stall_cnt + CNT_W'(1) : stall_cnt;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed and randomized checks of fwd_hazard_unit against a first-match behavioural model
module tb_fwd_hazard_unit;
  localparam int CW = 4;
  logic CLK, nRST;
  logic [4:0]  rs[2], ids[2], ws[2];
  logic [31:0] rd[2], sd[2];
  logic [1:0]  wen, rdy;
  logic ex_wen, ex_is_load, pipe_en, clr_cnt;
  logic [4:0] ex_wsel;
  logic [9:0]  ex_rsel, id_rsel, stage_wsel;
  logic [63:0] ex_rdat, stage_dat, rdat_out;
  logic [1:0]  fwd_hit;
  logic stall_req, bubble;
  logic [CW-1:0] stall_cnt;
  int errors = 0, checks = 0;
  logic m_rv, m_bub;
  logic [4:0] m_rsel;
  logic [31:0] m_rdat;
  int m_cnt;

  assign ex_rsel    = {rs[1], rs[0]};
  assign id_rsel    = {ids[1], ids[0]};
  assign stage_wsel = {ws[1], ws[0]};
  assign ex_rdat    = {rd[1], rd[0]};
  assign stage_dat  = {sd[1], sd[0]};

  fwd_hazard_unit #(.NREAD(2), .NSTAGE(2), .DATA_W(32), .REG_W(5), .CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .ex_rsel(ex_rsel), .ex_rdat(ex_rdat), .id_rsel(id_rsel),
    .ex_wen(ex_wen), .ex_wsel(ex_wsel), .ex_is_load(ex_is_load), .stage_wen(wen),
    .stage_wsel(stage_wsel), .stage_dat(stage_dat), .stage_rdy(rdy), .pipe_en(pipe_en),
    .clr_cnt(clr_cnt), .rdat_out(rdat_out), .fwd_hit(fwd_hit), .stall_req(stall_req),
    .bubble(bubble), .stall_cnt(stall_cnt));

  initial CLK = 0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      rs[i] = 0; ids[i] = 0; ws[i] = 0; rd[i] = 32'h1111_0000 + i; sd[i] = 0;
    end
    wen = 0; rdy = 2'b11; ex_wen = 0; ex_wsel = 0; ex_is_load = 0; pipe_en = 1; clr_cnt = 0;
  endtask

  // Reference: first matching source in age order wins; previous-cycle load-use suppresses a new one
  always @(negedge CLK) begin
    logic [31:0] ed;
    logic eh, enr, any_nr, lu, idm;
    int w;
    if (!nRST) begin
      chk("rst_stall_req", stall_req, 0);
      chk("rst_bubble", bubble, 0);
      chk("rst_fwd_hit", fwd_hit, 0);
      chk("rst_rdat_out", rdat_out, ex_rdat);
      chk("rst_stall_cnt", stall_cnt, 0);
      m_rv = 0; m_bub = 0; m_cnt = 0;
    end else begin
      any_nr = 0;
      for (int i = 0; i < 2; i++) begin
        ed = rd[i]; eh = 0; enr = 0; w = -1;
        for (int s = 0; s < 2; s++)
          if (w < 0 && wen[s] && ws[s] != 0 && ws[s] == rs[i]) w = s;
        if (w >= 0) begin eh = 1; enr = !rdy[w]; ed = sd[w]; end
        else if (m_rv && m_rsel == rs[i]) begin eh = 1; ed = m_rdat; end
        chk($sformatf("fwd_hit%0d", i), fwd_hit[i], eh);
        if (!enr) chk($sformatf("rdat_out%0d", i), rdat_out[i*32 +: 32], ed);
        any_nr |= enr;
      end
      idm = (ids[0] == ex_wsel) || (ids[1] == ex_wsel);
      lu = !m_bub && pipe_en && ex_is_load && ex_wen && ex_wsel != 0 && idm;
      chk("stall_req", stall_req, lu || any_nr);
      chk("bubble", bubble, lu);
      chk("stall_cnt", stall_cnt, m_cnt);
      m_bub = lu;
      m_rv = wen[1] && ws[1] != 0; m_rsel = ws[1]; m_rdat = sd[1];
      m_cnt = clr_cnt ? 0 : ((lu || any_nr) && m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt;
    end
  end

  initial begin
    idle();
    nRST = 0;
    wen = 2'b11; ws[0] = 3; ws[1] = 3; rs[0] = 3; sd[0] = 32'hAAAA;
    @(negedge CLK);
    chk("reset_fwd_hit", fwd_hit, 2'b00);
    chk("reset_rdat0", rdat_out[31:0], 32'h1111_0000);
    step(); step();
    nRST = 1;
    idle();
    // priority
    wen = 2'b11; ws[0] = 3; ws[1] = 3; sd[0] = 32'hAAAA; sd[1] = 32'hBBBB; rs[0] = 3;
    @(negedge CLK);
    chk("prio_young", rdat_out[31:0], 32'hAAAA);
    chk("prio_hit", fwd_hit[0], 1);
    step(); wen = 2'b10;
    @(negedge CLK);
    chk("prio_old", rdat_out[31:0], 32'hBBBB);
    // zero register
    step(); idle();
    wen = 2'b11; sd[0] = 32'hFFFF; sd[1] = 32'hFFFF; rd[0] = 0; rd[1] = 0;
    @(negedge CLK);
    chk("zero_rdat", rdat_out, 0);
    chk("zero_hit", fwd_hit, 0);
    // retired buffer
    step(); idle(); wen = 2'b10; ws[1] = 7; sd[1] = 32'h1234;
    step(); idle(); rs[1] = 7; rd[1] = 32'h5555;
    @(negedge CLK);
    chk("rb_rdat1", rdat_out[63:32], 32'h1234);
    chk("rb_hit1", fwd_hit[1], 1);
    step();
    @(negedge CLK);
    chk("rb_expired", rdat_out[63:32], 32'h5555);
    // load-use
    step(); idle(); clr_cnt = 1;
    step(); clr_cnt = 0; ex_is_load = 1; ex_wen = 1; ex_wsel = 5; ids[0] = 5;
    @(negedge CLK);
    chk("lu_stall", stall_req, 1);
    chk("lu_bubble", bubble, 1);
    step();
    @(negedge CLK);
    chk("lu_once_stall", stall_req, 0);
    chk("lu_once_bubble", bubble, 0);
    chk("lu_cnt", stall_cnt, 1);
    // not ready
    step(); idle(); clr_cnt = 1;
    step(); clr_cnt = 0; wen = 2'b01; ws[0] = 9; sd[0] = 32'h9999; rdy = 2'b10; rs[0] = 9;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("nr_stall", stall_req, 1);
      chk("nr_bubble", bubble, 0);
      step();
    end
    rdy = 2'b11;
    @(negedge CLK);
    chk("nr_cnt", stall_cnt, 3);
    chk("nr_stall_done", stall_req, 0);
    chk("nr_fwd", rdat_out[31:0], 32'h9999);
    // saturation and clear
    rdy = 2'b10;
    for (int k = 0; k < 20; k++) step();
    @(negedge CLK);
    chk("sat_cnt", stall_cnt, 15);
    step(); clr_cnt = 1;
    @(negedge CLK);
    chk("clr_stall", stall_req, 1);
    step(); clr_cnt = 0; idle();
    @(negedge CLK);
    chk("clr_cnt", stall_cnt, 0);
    // async reset while in LU_BUBBLE
    step(); ex_is_load = 1; ex_wen = 1; ex_wsel = 6; ids[1] = 6;
    step(); wen = 2'b01; ws[0] = 9; rdy = 2'b10; rs[0] = 9;
    #1;
    chk("pre_rst_stall", stall_req, 1);
    nRST = 0;
    #1;
    chk("async_stall", stall_req, 0);
    chk("async_bubble", bubble, 0);
    chk("async_cnt", stall_cnt, 0);
    chk("async_hit", fwd_hit, 0);
    step(); step();
    nRST = 1; idle();
    // random
    for (int n = 0; n < 600; n++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        rs[i] = 5'($urandom_range(0, 3)); ids[i] = 5'($urandom_range(0, 3));
        ws[i] = 5'($urandom_range(0, 3)); rd[i] = $urandom; sd[i] = $urandom;
      end
      wen = 2'($urandom); rdy = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      ex_wen = 1'($urandom); ex_is_load = 1'($urandom); ex_wsel = 5'($urandom_range(0, 3));
      pipe_en = ($urandom_range(0, 4) != 0); clr_cnt = ($urandom_range(0, 15) == 0);
      nRST = ($urandom_range(0, 63) != 0);
    end
    step(); nRST = 1; idle();
    @(negedge CLK);
    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
